// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix operand path.
//   ID_W / DIM_W   : widths of matrix slot IDs and of row/col dimensions
//   OP_*           : op_sel encodings (101..111 are illegal)
//   sel_state_t    : operand_selector FSM states
//   op_is_binary   : op needs a second operand B
//   op_is_legal    : op_sel is one of the defined codes
package matrix_pkg;

  localparam int ID_W  = 4;
  localparam int DIM_W = 3;

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_SCALAR    = 3'b010;
  localparam logic [2:0] OP_MUL       = 3'b011;
  localparam logic [2:0] OP_DET       = 3'b100;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_MAN_A,
    SEL_MAN_B,
    SEL_AUTO_A,
    SEL_AUTO_B,
    SEL_DONE,
    SEL_ERR
  } sel_state_t;

  function automatic logic op_is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_DET;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   lfsr_low   : low nibble of the LFSR state, used as a scan start point
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] lfsr_low
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign lfsr_low = lfsr_q[3:0];

endmodule

// File: rtl/operand_selector.sv
// operand_selector: picks operand matrix IDs A (and B for binary ops), either
// from switches confirmed by key_ok (manual) or by scanning the matrix store
// from a pseudo-random start slot (auto), checking store metadata per op.
//   start_select, manual_mode, op_sel : start / restart a selection
//   key_ok, sw_id                     : manual candidate and its confirm
//   meta_id -> meta_valid/rows/cols   : combinational store lookup
//   selected_a/b, select_done         : result, held in DONE
//   select_error                      : one-cycle failure pulse
//   busy                              : selection in progress
//
// state      | meaning
// IDLE       | waiting for start_select
// MAN_A      | waiting for key_ok on operand A
// MAN_B      | waiting for key_ok on operand B
// AUTO_A     | scanning slots for A, one per cycle
// AUTO_B     | scanning slots after A for a compatible B
// DONE       | result held, select_done high
// ERR        | one-cycle select_error, then IDLE
module operand_selector
  import matrix_pkg::*;
#(
  parameter int NUM_SLOTS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_select,
  input  logic             manual_mode,
  input  logic [2:0]       op_sel,
  input  logic             key_ok,
  input  logic [ID_W-1:0]  sw_id,
  output logic [ID_W-1:0]  meta_id,
  input  logic             meta_valid,
  input  logic [DIM_W-1:0] meta_rows,
  input  logic [DIM_W-1:0] meta_cols,
  output logic [ID_W-1:0]  selected_a,
  output logic [ID_W-1:0]  selected_b,
  output logic             select_done,
  output logic             select_error,
  output logic             busy
);

  localparam logic [ID_W:0]   SLOTS   = (ID_W+1)'(NUM_SLOTS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SLOTS - 1);

  sel_state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [ID_W-1:0]  scan_q, scan_next, scan_start;
  logic [ID_W:0]    remain_q;
  logic [ID_W-1:0]  a_id_q;
  logic [DIM_W-1:0] a_rows_q, a_cols_q;
  logic [3:0]       lfsr_low;
  logic             b_phase, cand_ok, last_cand, enter_done, latch_a;
  logic             done_d, error_d, busy_d;

  // Only B is checked against A; there is no rule for unary ops.
  function automatic logic dims_compatible(input logic [2:0] op,
                                           input logic [DIM_W-1:0] ar, ac, br, bc);
    case (op)
      OP_ADD:  return (ar == br) && (ac == bc);
      OP_MUL:  return ac == br;
      default: return 1'b1;
    endcase
  endfunction

  lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .lfsr_low (lfsr_low)
  );

  // Fold the 4-bit LFSR value into 0..NUM_SLOTS-1 with one subtraction;
  // NUM_SLOTS >= 8 guarantees a single step is enough.
  assign scan_start = ({1'b0, lfsr_low} < SLOTS) ? lfsr_low
                                                 : lfsr_low - SLOTS[ID_W-1:0];

  always_comb begin
    case (state_q)
      SEL_MAN_A, SEL_MAN_B:   meta_id = sw_id;
      SEL_AUTO_A, SEL_AUTO_B: meta_id = scan_q;
      default:                meta_id = '0;
    endcase
  end

  assign b_phase   = (state_q == SEL_MAN_B) || (state_q == SEL_AUTO_B);
  assign cand_ok   = ({1'b0, meta_id} < SLOTS) && meta_valid &&
                     (!b_phase || dims_compatible(op_q, a_rows_q, a_cols_q,
                                                  meta_rows, meta_cols));
  assign scan_next = (scan_q == LAST_ID) ? '0 : scan_q + 1'b1;
  assign last_cand = (remain_q == (ID_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEL_IDLE;
      select_done  <= 1'b0;
      select_error <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_done  <= done_d;
      select_error <= error_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_select) begin
      if (!op_is_legal(op_sel)) state_d = SEL_ERR;
      else if (manual_mode)     state_d = SEL_MAN_A;
      else                      state_d = SEL_AUTO_A;
    end else begin
      case (state_q)
        SEL_MAN_A:
          if (key_ok)
            state_d = !cand_ok ? SEL_ERR : (op_is_binary(op_q) ? SEL_MAN_B : SEL_DONE);
        SEL_MAN_B:
          if (key_ok) state_d = cand_ok ? SEL_DONE : SEL_ERR;
        SEL_AUTO_A:
          if (cand_ok)        state_d = op_is_binary(op_q) ? SEL_AUTO_B : SEL_DONE;
          else if (last_cand) state_d = SEL_ERR;
        SEL_AUTO_B:
          if (cand_ok)        state_d = SEL_DONE;
          else if (last_cand) state_d = SEL_ERR;
        SEL_ERR:  state_d = SEL_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    done_d  = (state_d == SEL_DONE);
    error_d = (state_d == SEL_ERR);
    busy_d  = (state_d != SEL_IDLE) && (state_d != SEL_DONE);
  end

  assign enter_done = (state_d == SEL_DONE) && (state_q != SEL_DONE);
  assign latch_a    = !start_select && cand_ok &&
                      (((state_q == SEL_MAN_A) && key_ok) || (state_q == SEL_AUTO_A));

  // selected_a/b only change on entry to DONE, so a failed attempt leaves
  // the previous result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_TRANSPOSE;
      scan_q     <= '0;
      remain_q   <= '0;
      a_id_q     <= '0;
      a_rows_q   <= '0;
      a_cols_q   <= '0;
      selected_a <= '0;
      selected_b <= '0;
    end else begin
      if (start_select) begin
        op_q     <= op_sel;
        scan_q   <= scan_start;
        remain_q <= SLOTS;
      end else if ((state_q == SEL_AUTO_A) || (state_q == SEL_AUTO_B)) begin
        // On accepting A the next slot is A+1, which is where the B scan starts.
        scan_q   <= scan_next;
        remain_q <= ((state_q == SEL_AUTO_A) && cand_ok) ? SLOTS : remain_q - 1'b1;
      end
      if (latch_a) begin
        a_id_q   <= meta_id;
        a_rows_q <= meta_rows;
        a_cols_q <= meta_cols;
      end
      if (enter_done) begin
        selected_a <= b_phase ? a_id_q : meta_id;
        selected_b <= meta_id;
      end
    end
  end

endmodule

// File: doc/operand_selector.md
# operand_selector

Chooses the operand matrix IDs for an operation and sits between the matrix store and `ctrl_fsm`. It is started by `start_select` and resolves matrix A and, for binary ops, matrix B, either from user switches (manual) or by a pseudo-random scan of stored matrices (auto). Each candidate is checked against the store's dimension metadata for the selected `op_sel`. It returns `selected_a`/`selected_b` with a held `select_done`, or a one-cycle `select_error` pulse.

## Interface
- `NUM_SLOTS`, default 10: number of matrix slots in the store; legal range 8..16; IDs `0..NUM_SLOTS-1`.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_select` in 1: one-cycle pulse; starts or restarts a selection.
- `manual_mode` in 1: sampled at `start_select`; 1 = manual, 0 = auto.
- `op_sel` in 3: sampled at `start_select`.
  - Unary ops: 000 transpose, 010 scalar, 100 determinant.
  - 001 add: A and B have the same dimensions.
  - 011 multiply: `a_cols == b_rows`.
  - 101–111: illegal.
- `key_ok` in 1: debounced one-cycle pulse; confirms the current manual choice.
- `sw_id` in 4: manual candidate ID.
- `meta_id` out 4: store lookup address, combinational.
- `meta_valid` in 1: slot holds a matrix; combinational same-cycle response to `meta_id`.
- `meta_rows`, `meta_cols` in 3 each: dimensions of the addressed slot, 1..5.
- `selected_a`, `selected_b` out 4: chosen IDs.
- `select_done` out 1: level; high while in DONE.
- `select_error` out 1: one-cycle pulse.
- `busy` out 1: high in any state other than IDLE or DONE.

## Operation
- States: IDLE, MAN_A, MAN_B, AUTO_A, AUTO_B, DONE, ERR.
- `start_select` in any state:
  - Latches `op_sel` and `manual_mode`.
  - Clears `select_done`.
  - Goes to MAN_A if `manual_mode` = 1, else AUTO_A. The scan counter is loaded from the LFSR (see AUTO_A).
- If `op_sel` is illegal at `start_select`: go directly to ERR instead.
- A candidate ID is acceptable only if all three hold: ID < `NUM_SLOTS`, `meta_valid` = 1, and the compatibility rule for `op_sel` is met. The rule applies to B only.
- `meta_id` source: `sw_id` in MAN_A/MAN_B; scan counter in AUTO_A/AUTO_B; 0 otherwise.
- MAN_A:
  - On `key_ok`, if the candidate is acceptable: latch the ID, rows and cols as A.
  - Then go to MAN_B for binary ops. For unary ops set `selected_b` = A and go to DONE.
  - On `key_ok` with an unacceptable candidate: go to ERR.
- MAN_B: same as MAN_A, with the compatibility rule applied against the latched A dims. Accept leads to DONE; reject leads to ERR.
- AUTO_A:
  - The scan counter starts at `lfsr[3:0]` if it is < `NUM_SLOTS`, else at `lfsr[3:0] - NUM_SLOTS`.
  - One candidate per cycle; the counter wraps `NUM_SLOTS-1` → 0.
  - First acceptable slot becomes A. Then go to AUTO_B, or to DONE for unary ops.
  - `NUM_SLOTS` consecutive rejects: go to ERR.
- AUTO_B:
  - Scan starts at A+1 (wrapping), runs `NUM_SLOTS` candidates, and the last candidate is A itself.
  - First compatible slot becomes B; go to DONE. Exhausted scan: go to ERR.
- DONE: hold `select_done` = 1 and the IDs until the next `start_select` or reset.
- ERR: `select_error` = 1 for exactly one cycle, then IDLE. `selected_a`/`selected_b` keep their previous values.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Reset seed 8'hA5. Free-runs every cycle.

## Timing
- Reset values: state IDLE; `selected_a` = 0, `selected_b` = 0; `select_done` = 0; `select_error` = 0; `busy` = 0; LFSR = 8'hA5.
- All outputs except `meta_id` are registered.
- Manual latency: the `key_ok` cycle decides; the result is visible on the next edge.
- Auto latency, unary op: `select_done` rises at most `NUM_SLOTS`+1 cycles after `start_select`.
- Auto latency, binary op: at most 2·`NUM_SLOTS`+1 cycles.
- `key_ok` is ignored in AUTO states, DONE and IDLE.
- `start_select` and `key_ok` in the same cycle: `start_select` wins.
- Reset mid-scan: immediate return to IDLE; no done or error pulse is produced.

## Structure
- Shared package `matrix_pkg`, holding:
  - Op-code localparams: `OP_TRANSPOSE`, `OP_ADD`, `OP_SCALAR`, `OP_MUL`, `OP_DET`.
  - `ID_W` = 4 and `DIM_W` = 3.
  - Function `op_is_binary`.
- Sub-module `lfsr8`: the free-running LFSR with seed parameter.
- The compatibility check is a combinational function in the block.

## Test plan
- Manual add: slots 2 and 7 both 3×3. `start_select` with op 001, manual. `sw_id`=2 + `key_ok`, then `sw_id`=7 + `key_ok` → `selected_a`=2, `selected_b`=7, `select_done` high.
- Manual multiply mismatch: A = slot 1 (2×3), B = slot 4 (2×2) → `select_error` pulses for 1 cycle, `select_done` stays 0, `busy` drops.
- Manual invalid ID: `sw_id`=12 with `NUM_SLOTS`=10, confirmed by `key_ok` in MAN_A → error pulse.
- Auto unary, only slot 5 valid, op 000 → `selected_a` = `selected_b` = 5 within 11 cycles.
- Auto binary multiply, slot 3 (2×4) and slot 8 (4×1) are the only matches → A = 3, B = 8, or the error pulse if the scan order picks A = 8 and finds no B. Also: empty store → error pulse exactly 11 cycles after start.
- Restart and reset:
  - `start_select` in DONE clears `select_done` on the next edge.
  - `rst_n` low mid AUTO_B → all outputs return to reset values, with no spurious pulse.
  - Op 110 → error pulse on the cycle after start.
